// File: rtl/ram_access_controller_if.sv
// Core-side request, write-beat and read-beat channels of the RAM access controller.
// The controller takes the slave modport; CPU/DMA logic takes the master modport.
interface ram_access_controller_if #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LEN_WIDTH-1:0]  req_len;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_last;
    logic                  busy;

    modport master (
        output req_valid,
        input  req_ready,
        output req_we,
        output req_addr,
        output req_len,
        output wr_data,
        output wr_valid,
        input  wr_ready,
        input  rd_data,
        input  rd_valid,
        input  rd_last,
        input  busy
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_we,
        input  req_addr,
        input  req_len,
        input  wr_data,
        input  wr_valid,
        output wr_ready,
        output rd_data,
        output rd_valid,
        output rd_last,
        output busy
    );
endinterface

// File: rtl/ram_access_controller.sv
// Bus master for a single-port synchronous RAM: turns core read/write bursts into
// registered cs/we/oe/addr strobes and owns the tri-state data bus while writing.
module ram_access_controller #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_access_controller_if.slave core,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StWdrain
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  mem_cs_q, mem_cs_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_oe_q, mem_oe_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_last_q, rd_last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            dout_q     <= '0;
            mem_cs_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_oe_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            dout_q     <= dout_d;
            mem_cs_q   <= mem_cs_d;
            mem_we_q   <= mem_we_d;
            mem_oe_q   <= mem_oe_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        dout_d     = dout_q;
        mem_cs_d   = mem_cs_q;
        mem_we_d   = mem_we_q;
        mem_oe_d   = mem_oe_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                mem_cs_d = 1'b0;
                mem_we_d = 1'b0;
                mem_oe_d = 1'b0;
                if (core.req_valid) begin
                    addr_d = core.req_addr;
                    cnt_d  = core.req_len;
                    if (core.req_we) begin
                        state_d = StWrite;
                    end else begin
                        // First read bus cycle starts right after the accept edge.
                        state_d    = StRead;
                        mem_addr_d = core.req_addr;
                        mem_cs_d   = 1'b1;
                        mem_oe_d   = 1'b1;
                    end
                end
            end

            StRead: begin
                rd_data_d  = mem_data;
                rd_valid_d = 1'b1;
                if (cnt_q == '0) begin
                    rd_last_d = 1'b1;
                    mem_cs_d  = 1'b0;
                    mem_oe_d  = 1'b0;
                    state_d   = StIdle;
                end else begin
                    mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
                    cnt_d      = cnt_q - LEN_WIDTH'(1);
                end
            end

            StWrite: begin
                mem_oe_d = 1'b0;
                if (core.wr_valid) begin
                    mem_addr_d = addr_q;
                    addr_d     = addr_q + ADDR_WIDTH'(1);
                    dout_d     = core.wr_data;
                    mem_cs_d   = 1'b1;
                    mem_we_d   = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = StWdrain;
                    end else begin
                        cnt_d = cnt_q - LEN_WIDTH'(1);
                    end
                end else begin
                    // Stall: idle the bus, keep address and count.
                    mem_cs_d = 1'b0;
                    mem_we_d = 1'b0;
                end
            end

            StWdrain: begin
                mem_cs_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign core.req_ready = (state_q == StIdle);
    assign core.wr_ready  = (state_q == StWrite);
    assign core.busy      = (state_q != StIdle);
    assign core.rd_data   = rd_data_q;
    assign core.rd_valid  = rd_valid_q;
    assign core.rd_last   = rd_last_q;

    assign mem_addr = mem_addr_q;
    assign mem_cs   = mem_cs_q;
    assign mem_we   = mem_we_q;
    assign mem_oe   = mem_oe_q;

    // Only a write bus cycle drives the shared data bus.
    assign mem_data = (mem_cs_q && mem_we_q) ? dout_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_access_controller.sv
// Directed bench for ram_access_controller with a behavioural single-port RAM
// (latches read data on negedge, commits writes on posedge).
module tb_ram_access_controller;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 8;
    localparam int unsigned LW = 4;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_data;
    logic          mem_cs;
    logic          mem_we;
    logic          mem_oe;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ram_q;
    logic [DW-1:0] dat [0:15];

    ram_access_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) rif ();

    ram_access_controller #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .core    (rif),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_cs  (mem_cs),
        .mem_we  (mem_we),
        .mem_oe  (mem_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (mem_cs && !mem_we) ram_q <= ram[mem_addr];
    always @(posedge clk) if (mem_cs && mem_we) ram[mem_addr] <= mem_data;
    assign mem_data = (mem_cs && mem_oe && !mem_we) ? ram_q : {DW{1'bz}};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write dat[0..n-1] from a; optional stall of gap_len cycles after beat gap_beat.
    task automatic wr_burst(input logic [AW-1:0] a, input int n, input int gap_beat,
                            input int gap_len);
        rif.req_valid = 1'b1;
        rif.req_we    = 1'b1;
        rif.req_addr  = a;
        rif.req_len   = LW'(n - 1);
        @(negedge clk);
        rif.req_valid = 1'b0;
        chk("wr_busy", rif.busy, 1);
        chk("wr_ready_on", rif.wr_ready, 1);
        for (int i = 0; i < n; i++) begin
            rif.wr_valid = 1'b1;
            rif.wr_data  = dat[i];
            @(negedge clk);
            chk("wr_cs", mem_cs, 1);
            chk("wr_we", mem_we, 1);
            chk("wr_oe", mem_oe, 0);
            chk("wr_addr", mem_addr, AW'(a + AW'(i)));
            chk("wr_bus", mem_data, dat[i]);
            chk("wr_no_rdv", rif.rd_valid, 0);
            if (i == gap_beat) begin
                rif.wr_valid = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    chk("wr_stall_cs", mem_cs, 0);
                    chk("wr_stall_we", mem_we, 0);
                end
            end
        end
        rif.wr_valid = 1'b0;
        chk("wr_drain_ready", rif.wr_ready, 0);
        @(negedge clk);
        chk("wr_end_cs", mem_cs, 0);
        chk("wr_end_req_ready", rif.req_ready, 1);
    endtask

    // Read n beats from a, expecting dat[0..n-1].
    task automatic rd_burst(input logic [AW-1:0] a, input int n);
        rif.req_valid = 1'b1;
        rif.req_we    = 1'b0;
        rif.req_addr  = a;
        rif.req_len   = LW'(n - 1);
        @(negedge clk);
        rif.req_valid = 1'b0;
        chk("rd_first_cs", mem_cs, 1);
        chk("rd_first_oe", mem_oe, 1);
        chk("rd_first_we", mem_we, 0);
        chk("rd_first_rdv", rif.rd_valid, 0);
        chk("rd_addr", mem_addr, a);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rd_valid", rif.rd_valid, 1);
            chk("rd_data", rif.rd_data, dat[i]);
            chk("rd_last", rif.rd_last, (i == n - 1) ? 1 : 0);
            if (i < n - 1) chk("rd_addr", mem_addr, AW'(a + AW'(i + 1)));
        end
        chk("rd_end_cs", mem_cs, 0);
        chk("rd_end_oe", mem_oe, 0);
        chk("rd_end_req_ready", rif.req_ready, 1);
        @(negedge clk);
        chk("rd_after_rdv", rif.rd_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
        ram_q        = '0;
        rif.req_valid = 1'b0;
        rif.req_we    = 1'b0;
        rif.req_addr  = '0;
        rif.req_len   = '0;
        rif.wr_data   = '0;
        rif.wr_valid  = 1'b0;

        // 1: asynchronous reset, observed before any clock edge
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_cs", mem_cs, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_oe", mem_oe, 0);
        chk("rst_req_ready", rif.req_ready, 1);
        chk("rst_rd_valid", rif.rd_valid, 0);
        chk("rst_busy", rif.busy, 0);
        chk("rst_addr", mem_addr, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 2: single write then single read
        dat[0] = 8'hA5;
        wr_burst(13'h0010, 1, -1, 0);
        rd_burst(13'h0010, 1);

        // 3: burst write with 2-cycle stall after beat 2, then read back
        dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;
        wr_burst(13'h0100, 4, 1, 2);
        rd_burst(13'h0100, 4);

        // 4: address wrap at top of memory
        dat[0] = 8'h5A; dat[1] = 8'h6B; dat[2] = 8'h7C; dat[3] = 8'h8D;
        wr_burst(13'h1FFE, 4, -1, 0);
        rd_burst(13'h1FFE, 4);

        // 5: reset in the middle of an 8-beat read
        rif.req_valid = 1'b1;
        rif.req_we    = 1'b0;
        rif.req_addr  = 13'h0100;
        rif.req_len   = 4'd7;
        @(negedge clk);
        rif.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_beat", rif.rd_data, (i == 0) ? 32'h11 : (i == 1) ? 32'h22 : 32'h33);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_rdv", rif.rd_valid, 0);
        chk("rst_mid_cs", mem_cs, 0);
        chk("rst_mid_oe", mem_oe, 0);
        chk("rst_mid_busy", rif.busy, 0);
        @(negedge clk);
        chk("rst_hold_rdv", rif.rd_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        dat[0] = 8'h6B;
        rd_burst(13'h1FFF, 1);

        // 6: request held during a burst is accepted right after rd_last
        rif.req_valid = 1'b1;
        rif.req_we    = 1'b0;
        rif.req_addr  = 13'h0100;
        rif.req_len   = 4'd3;
        @(negedge clk);
        rif.req_addr  = 13'h0010;
        rif.req_len   = 4'd0;
        for (int i = 0; i < 3; i++) begin
            chk("hold_req_ready", rif.req_ready, 0);
            @(negedge clk);
        end
        chk("hold_req_ready", rif.req_ready, 0);
        @(negedge clk);
        chk("hold_last", rif.rd_last, 1);
        chk("hold_last_data", rif.rd_data, 8'h44);
        chk("hold_gap_cs", mem_cs, 0);
        chk("hold_idle_ready", rif.req_ready, 1);
        @(negedge clk);
        rif.req_valid = 1'b0;
        chk("hold_accept_cs", mem_cs, 1);
        chk("hold_accept_addr", mem_addr, 13'h0010);
        chk("hold_accept_busy", rif.busy, 1);
        chk("hold_gap_rdv", rif.rd_valid, 0);
        @(negedge clk);
        chk("hold_rd_valid", rif.rd_valid, 1);
        chk("hold_rd_data", rif.rd_data, 8'hA5);
        chk("hold_rd_last", rif.rd_last, 1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
